// File: rtl/bus_endpoint_port.sv
// ---------------------------------------------------------------------------
// bus_endpoint_port
//
// Terminal-side endpoint for the bs_gnrtr_n_rbtr bus. The host loads packets
// into a transmit FIFO, and the bus pops them through a show-ahead source
// interface. The bus delivers packets with push/D_push into a receive FIFO,
// and the host drains that FIFO through a valid/ready port. The destination
// ID sits in the top byte of every packet.
//
// Optional feature macro: BUS_EP_ADDR_FILTER_EN
//   defined   - only packets addressed to id or broadcast are accepted
//   undefined - promiscuous: every push is a candidate for the RX FIFO
//
// Parameters:
//   pckg_sz   packet width in bits (>= 9)
//   depth     entries per FIFO (power of two, >= 2)
//   id        this terminal's 8-bit bus ID
//   broadcast destination ID every terminal accepts
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous active-low reset
//   tx_valid   host offers tx_data          tx_ready  TX FIFO not full
//   tx_data    packet to transmit
//   pndng      TX FIFO not empty            D_pop     TX head (0 when empty)
//   pop        bus consumes the TX head
//   push       bus delivers D_push          D_push    delivered packet
//   rx_valid   RX FIFO not empty            rx_data   RX head (0 when empty)
//   rx_ready   host consumes the RX head
//   drop_cnt   saturating count of deliveries lost to a full RX FIFO
// ---------------------------------------------------------------------------
module bus_endpoint_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [7:0]         drop_cnt
);

  localparam int              aw       = $clog2(depth);
  localparam logic [aw:0]     full_cnt = (aw+1)'(depth);

  // Transmit FIFO state
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [aw-1:0]      tx_wp;
  logic [aw-1:0]      tx_rp;
  logic [aw:0]        tx_cnt;
  logic               tx_wr;
  logic               tx_rd;

  // Receive FIFO state
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw-1:0]      rx_wp;
  logic [aw-1:0]      rx_rp;
  logic [aw:0]        rx_cnt;
  logic               rx_full;
  logic               rx_rd;
  logic               rx_acc;
  logic               rx_drop;

  logic [7:0]         dest;
  logic               addr_ok;

  // Status flags come only from registered counts, so no input reaches an
  // output combinationally. Heads are forced to 0 while a FIFO is empty.
  assign tx_ready = (tx_cnt != full_cnt);
  assign pndng    = (tx_cnt != '0);
  assign D_pop    = pndng ? tx_mem[tx_rp] : '0;

  assign rx_valid = (rx_cnt != '0);
  assign rx_full  = (rx_cnt == full_cnt);
  assign rx_data  = rx_valid ? rx_mem[rx_rp] : '0;

  assign tx_wr = tx_valid && tx_ready;
  assign tx_rd = pop && pndng;

  assign dest = D_push[pckg_sz-1:pckg_sz-8];

`ifdef BUS_EP_ADDR_FILTER_EN
  assign addr_ok = (dest == id) || (dest == broadcast);
`else
  // Promiscuous: the ID compare is folded away, every push passes.
  assign addr_ok = 1'b1 | (dest == id) | (dest == broadcast);
`endif

  // A host pop frees the slot in the same cycle, so a full RX FIFO can still
  // accept when the host is reading. Only a full FIFO with no read drops.
  assign rx_rd   = rx_valid && rx_ready;
  assign rx_acc  = push && addr_ok && (!rx_full || rx_rd);
  assign rx_drop = push && addr_ok && rx_full && !rx_ready;

  // TX pointers and count. A simultaneous write and pop leaves the count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_wr) tx_wp <= tx_wp + 1'b1;
      if (tx_rd) tx_rp <= tx_rp + 1'b1;
      case ({tx_wr, tx_rd})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp] <= tx_data;
  end

  // RX pointers, count and the saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (rx_acc) rx_wp <= rx_wp + 1'b1;
      if (rx_rd)  rx_rp <= rx_rp + 1'b1;
      case ({rx_acc, rx_rd})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // RX storage; when full with a concurrent read the write lands in the slot
  // being vacated, which is safe because both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rx_acc) rx_mem[rx_wp] <= D_push;
  end

endmodule

// File: doc/bus_endpoint_port.md
# bus_endpoint_port

Terminal-side endpoint for the `bs_gnrtr_n_rbtr` bus: it presents the FIFO-style source interface the bus pops from (`pndng`/`pop`/`D_pop`) and sinks the bus's `push`/`D_push` deliveries. The block is the hardware counterpart of the per-terminal driver/monitor pair in the test bench.

- Host side: a transmit FIFO loaded through a valid/ready write port, and a receive FIFO drained through a valid/ready read port.
- Packets are `pckg_sz` bits wide, and bits `[pckg_sz-1:pckg_sz-8]` hold the destination ID.
- One instance sits at each of the `drvrs` terminals of the bus.

## Interface
- `pckg_sz`, default 16: packet width in bits. Must be at least 9.
- `depth`, default 8: entries in each FIFO. Must be a power of two and at least 2.
- `id`, default 8'd0: this terminal's 8-bit bus ID.
- `broadcast`, default 8'hFF: destination ID that every terminal accepts.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `tx_valid`, input, 1: host offers a packet for transmission.
- `tx_data`, input, `pckg_sz`: packet to transmit.
- `tx_ready`, output, 1: transmit FIFO is not full.
- `pndng`, output, 1: transmit FIFO is not empty.
- `D_pop`, output, `pckg_sz`: head of the transmit FIFO (show-ahead).
- `pop`, input, 1: bus consumes the head entry.
- `push`, input, 1: bus delivers a packet.
- `D_push`, input, `pckg_sz`: delivered packet.
- `rx_valid`, output, 1: receive FIFO is not empty.
- `rx_data`, output, `pckg_sz`: head of the receive FIFO.
- `rx_ready`, input, 1: host consumes the receive head.
- `drop_cnt`, output, 8: count of dropped deliveries, saturating at 8'hFF.

## Operation
- Each FIFO has a circular buffer, read and write pointers of `$clog2(depth)` bits that wrap modulo `depth`, and a count of `$clog2(depth)+1` bits.
- **TX write:** when `tx_valid && tx_ready`, store `tx_data` at the write pointer and advance it.
- **TX pop:** when `pop && pndng`, advance the read pointer. A `pop` while empty is ignored and nothing changes.
- **TX simultaneous write and pop:** both take effect and the count is unchanged. When the FIFO is full, `tx_ready` is 0, so a pop frees space only for the next cycle.
- **RX accept:** `push` is accepted when the address check passes (see Configuration) and the receive FIFO is not full. The data is stored and the count incremented.
- **RX pop:** when `rx_valid && rx_ready`, advance the read pointer. A simultaneous accept and pop is permitted at any fill level, including full: the pop frees the slot in the same cycle.
- **Drop:** a `push` that passes the address check while the RX FIFO is full and `rx_ready` is 0 increments `drop_cnt`. The counter saturates at 8'hFF and does not wrap.
- A `push` whose address does not match is silently ignored and is not counted.
- `push` has no backpressure: the bus never waits on this block.

## Timing
- Outputs at reset:
  - `tx_ready` = 1, `pndng` = 0, `D_pop` = 0.
  - `rx_valid` = 0, `rx_data` = 0, `drop_cnt` = 0.
  - All pointers and counts = 0.
- `pndng`, `tx_ready` and `rx_valid` are decoded from the registered counts. There is no combinational path from `pop`, `push`, `tx_valid` or `rx_ready` to any output.
- `D_pop` and `rx_data` are driven to 0 whenever their FIFO is empty.
- Latencies:
  - Host write at edge N: `pndng` and `D_pop` are valid after edge N.
  - Pop at edge N: the next entry appears on `D_pop` after edge N.
  - `push` at edge N: `rx_valid` and `rx_data` are valid after edge N.
- Reset asserted mid-operation flushes both FIFOs and clears `drop_cnt` immediately; stored contents are discarded.
- Deassertion of `reset` takes effect at the first `clk` edge after the release.

## Configuration
- **`BUS_EP_ADDR_FILTER_EN` defined:** a `push` passes the address check only if `D_push[pckg_sz-1:pckg_sz-8]` equals `id` or `broadcast`. All other packets are ignored.
- **`BUS_EP_ADDR_FILTER_EN` undefined:** every `push` passes the address check (promiscuous mode). The `id` parameter is unused, and `drop_cnt` counts every push lost to a full RX FIFO.

## Test plan
All scenarios use `pckg_sz`=16, `depth`=4, `id`=8'd2, with the filter enabled unless stated.
- **TX ordering:** write 16'h0201, 16'h0302, 16'h0403 (one per cycle), then pulse `pop` three times. `D_pop` shows 0201, 0302, 0403 in order, and `pndng` falls after the third pop.
- **TX full:** write 4 packets. `tx_ready` goes to 0. Then `pop` and `tx_valid` in the same cycle: the pop is taken, the write is refused, and `tx_ready` is 1 on the next cycle.
- **Address filter:**
  - `push` 16'h0255 → accepted, `rx_data`=16'h0255.
  - `push` 16'hFF66 → accepted.
  - `push` 16'h0377 → ignored, `drop_cnt`=0.
  - With the macro undefined, 16'h0377 is accepted.
- **RX overflow:** with `rx_ready`=0, push five packets with ID 02. Four are stored and `drop_cnt`=1. Then 300 more pushes → `drop_cnt` holds at 8'hFF.
- **Reset mid-operation:** with 3 TX and 2 RX entries and `drop_cnt`=5, assert `reset` low between edges. `pndng`, `rx_valid`, `drop_cnt` and `D_pop` go to 0 immediately, without waiting for a clock edge.
- **Empty pop:** `pop` while `pndng`=0 → no pointer movement; a subsequent write appears correctly on `D_pop`.
